ctl_duck_spawner: RTL and testbench
===================================

// Module: ctl_duck_spawner
// PURPOSE
//  Launch-side controller for the duck position controller: drives per-duck flight parameters (direction, reflections, speeds, start_x)
//  from a 16-bit LFSR, times each flight in frames, ends it on hit or escape, and sequences DUCKS_PER_ROUND ducks per round.
//  Sits between game logic (start, level, hit detector) and the duck position controller.
// PARAMETERS
//  DUCKS_PER_ROUND   10      ducks launched per round (1..15)
//  FLIGHT_FRAMES     300     new_frame pulses before a flying duck escapes (1..1023)
//  GAP_FRAMES        60      new_frame pulses between end of one duck and next launch (1..255)
//  MIN_SPD           3       base speed added to random part; results saturate at 31
//  LFSR_SEED         16'hACE1  reset value of the LFSR (must be nonzero)
// PORTS
//  clk              in   1   system clock
//  rst              in   1   asynchronous, active-high reset
//  new_frame        in   1   one-cycle pulse per video frame
//  round_start      in   1   one-cycle pulse; starts a round when idle, ignored otherwise
//  level            in   2   difficulty, sampled at launch
//  duck_hit         in   1   level/pulse from hit detection; meaningful only while FLYING
//  duck_direction   out  1   1 = right, 0 = left; stable for whole flight
//  reflections      out  5   nonzero only from LAUNCH through FLYING, else 0
//  duck_v_spd       out  5   vertical speed, 1..31, stable for whole flight
//  duck_h_spd       out  5   horizontal speed, 1..31, stable for whole flight
//  duck_start_x     out 10   start column, 64..575, stable for whole flight
//  duck_ctl_rst     out  1   one-cycle pulse returning the position controller to idle
//  duck_shot        out  1   one-cycle pulse: duck ended by hit
//  duck_escaped     out  1   one-cycle pulse: duck ended by timeout
//  ducks_left       out  4   ducks still to launch in current round
//  round_active     out  1   high from round_start acceptance to round_done
//  round_done       out  1   one-cycle pulse after last duck's gap expires
// BEHAVIOUR
//  Reset: state IDLE, LFSR=LFSR_SEED, all outputs 0, counters 0.
//  LFSR: Fibonacci x^16+x^14+x^13+x^11+1, steps every clk (not frame-gated); never reaches 0.
//  FSM: IDLE -> GAP -> LAUNCH -> FLYING -> END -> GAP ... -> DONE -> IDLE.
//   IDLE: on round_start: ducks_left<=DUCKS_PER_ROUND, round_active<=1, frame_ctr<=0, -> GAP.
//   GAP: frame_ctr counts new_frame; at GAP_FRAMES: if ducks_left==0 -> DONE, else -> LAUNCH.
//   LAUNCH (1 cycle): register params from current LFSR lfsr[15:0]:
//    duck_direction=lfsr[15]; duck_h_spd=sat31(MIN_SPD+2*level+lfsr[2:0]);
//    duck_v_spd=sat31(MIN_SPD+2*level+lfsr[5:3]); duck_start_x=64+lfsr[14:6];
//    reflections=1+lfsr[9:7] (1..8); ducks_left-=1; frame_ctr<=0; -> FLYING.
//    Arithmetic in 7 bits then saturate; v_spd/h_spd never 0.
//   FLYING: frame_ctr counts new_frame. duck_hit=1 -> END with duck_shot. Else frame_ctr reaching
//    FLIGHT_FRAMES -> END with duck_escaped. Hit and final timeout frame in same cycle: hit wins.
//   END (1 cycle): pulse duck_ctl_rst and exactly one of duck_shot/duck_escaped; reflections<=0; frame_ctr<=0; -> GAP.
//   DONE (1 cycle): pulse round_done, round_active<=0 -> IDLE.
//  Params outputs are registered, change only in LAUNCH, hold otherwise (including after END).
//  round_start outside IDLE: ignored, no restart. duck_hit outside FLYING: ignored.
//  frame_ctr 10 bits; compare with ==, no wrap possible given parameter ranges.
//  rst mid-flight: immediate return to reset state; no pulses emitted.
//  Latency: duck_hit to duck_shot/duck_ctl_rst = 1 cycle (END registered output asserted cycle after detection).
// STRUCTURE
//  Shared package duck_pkg: spawner state enum (IDLE,GAP,LAUNCH,FLYING,END,DONE), SPD_MAX=31,
//   START_X_MIN=64, LFSR taps constant.
//  Sub-module lfsr16 (clk, rst, seed param, out[15:0]); rest is one FSM + counters in this file.
// TESTING
//  1. round_start, GAP_FRAMES=2, FLIGHT_FRAMES=5, no hit -> duck_escaped after 5th frame of flight, ducks_left decrements each duck.
//  2. duck_hit during FLYING frame 2 -> duck_shot + duck_ctl_rst next cycle, reflections=0, no duck_escaped.
//  3. DUCKS_PER_ROUND=3 full round -> exactly 3 LAUNCH, round_done one pulse, round_active low after, ducks_left=0.
//  4. level=3, MIN_SPD=28 -> duck_h_spd=duck_v_spd=31 (saturated), never 0; start_x always 64..575 over 1000 launches.
//  5. duck_hit and timeout frame same cycle -> duck_shot only; round_start during FLYING -> ignored.
//  6. async rst asserted mid-FLYING between clk edges -> all outputs 0 immediately, state IDLE, LFSR=LFSR_SEED.

Source files
------------

// File: rtl/duck_pkg.sv
// -----------------------------------------------------------------------------
// duck_pkg
//   Shared definitions for the duck spawner slice: the spawner FSM state
//   encoding, speed/start-column limits, the LFSR feedback tap mask and a
//   speed saturation helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package duck_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        LAUNCH = 3'd2,
        FLYING = 3'd3,
        END    = 3'd4,
        DONE   = 3'd5
    } spawn_state_e;

    localparam int unsigned SPD_MAX     = 31;
    localparam int unsigned START_X_MIN = 64;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the feedback
    // bit is the parity of register bits 0, 2, 3 and 5, shifted in at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'b0000_0000_0010_1101;

    // Clamp a 7-bit speed sum into 1..SPD_MAX so a flight never stalls.
    function automatic logic [4:0] sat_spd(input logic [6:0] v);
        logic [4:0] r;
        if (v > 7'(SPD_MAX)) begin
            r = 5'(SPD_MAX);
        end else if (v == 7'd0) begin
            r = 5'd1;
        end else begin
            r = v[4:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ctl_duck_spawner_if.sv
// -----------------------------------------------------------------------------
// ctl_duck_spawner_if
//   Bundle between game logic (master) and the duck spawner (slave).
//   Signal contract: there is no valid/ready pair here. Every input pulse
//   (new_frame, round_start) is a single-cycle strobe sampled on the rising
//   clock edge; duck_hit is a level or pulse that only matters while a duck
//   is flying. Every output pulse (duck_ctl_rst, duck_shot, duck_escaped,
//   round_done) is high for exactly one clock. Flight parameters are held
//   registers that only change on the cycle after a launch.
//   Signals:
//     game -> spawner : new_frame, round_start, level[1:0], duck_hit
//     spawner -> game : duck_direction, reflections[4:0], duck_v_spd[4:0],
//                       duck_h_spd[4:0], duck_start_x[9:0], duck_ctl_rst,
//                       duck_shot, duck_escaped, ducks_left[3:0],
//                       round_active, round_done, dbg_state (FSM state)
// -----------------------------------------------------------------------------
interface ctl_duck_spawner_if;
    import duck_pkg::*;

    logic         new_frame;
    logic         round_start;
    logic [1:0]   level;
    logic         duck_hit;

    logic         duck_direction;
    logic [4:0]   reflections;
    logic [4:0]   duck_v_spd;
    logic [4:0]   duck_h_spd;
    logic [9:0]   duck_start_x;
    logic         duck_ctl_rst;
    logic         duck_shot;
    logic         duck_escaped;
    logic [3:0]   ducks_left;
    logic         round_active;
    logic         round_done;
    spawn_state_e dbg_state;

    modport master (
        output new_frame, round_start, level, duck_hit,
        input  duck_direction, reflections, duck_v_spd, duck_h_spd,
               duck_start_x, duck_ctl_rst, duck_shot, duck_escaped,
               ducks_left, round_active, round_done, dbg_state
    );

    modport slave (
        input  new_frame, round_start, level, duck_hit,
        output duck_direction, reflections, duck_v_spd, duck_h_spd,
               duck_start_x, duck_ctl_rst, duck_shot, duck_escaped,
               ducks_left, round_active, round_done, dbg_state
    );

endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR, advancing every clock. Seeded on
//   reset; with a nonzero seed it never reaches the all-zero state.
//   Ports:
//     clk  in   system clock
//     rst  in   asynchronous active-high reset (loads SEED)
//     out  out  current register value [15:0]
// -----------------------------------------------------------------------------
module lfsr16
    import duck_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/ctl_duck_spawner.sv
// -----------------------------------------------------------------------------
// ctl_duck_spawner
//   Launch-side controller for the duck position controller. Per round it
//   launches DUCKS_PER_ROUND ducks, each with random flight parameters drawn
//   from an LFSR, times the flight in video frames, ends it on hit or
//   escape, and separates ducks by GAP_FRAMES frames.
//   Ports:
//     clk  in   system clock
//     rst  in   asynchronous active-high reset
//     bus  slave side of ctl_duck_spawner_if (game inputs, duck outputs,
//          FSM state for observation)
// -----------------------------------------------------------------------------
module ctl_duck_spawner
    import duck_pkg::*;
#(
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned FLIGHT_FRAMES   = 300,
    parameter int unsigned GAP_FRAMES      = 60,
    parameter int unsigned MIN_SPD         = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    ctl_duck_spawner_if.slave bus
);

    // Counters compare against "last frame" so the transition happens on
    // the edge that samples the N-th new_frame pulse.
    localparam logic [9:0] GAP_LAST    = 10'(GAP_FRAMES - 1);
    localparam logic [9:0] FLIGHT_LAST = 10'(FLIGHT_FRAMES - 1);

    spawn_state_e state_q, state_d;
    logic [9:0]   frame_ctr_q, frame_ctr_d;
    logic [3:0]   ducks_left_q, ducks_left_d;
    logic         round_active_q, round_active_d;
    logic         round_done_q, round_done_d;
    logic         direction_q, direction_d;
    logic [4:0]   reflections_q, reflections_d;
    logic [4:0]   v_spd_q, v_spd_d;
    logic [4:0]   h_spd_q, h_spd_d;
    logic [9:0]   start_x_q, start_x_d;
    logic         ctl_rst_q, ctl_rst_d;
    logic         shot_q, shot_d;
    logic         escaped_q, escaped_d;

    logic [15:0]  lfsr;
    logic         gap_expire;
    logic         flight_expire;
    logic [6:0]   spd_base;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr)
    );

    assign gap_expire    = bus.new_frame && (frame_ctr_q == GAP_LAST);
    assign flight_expire = bus.new_frame && (frame_ctr_q == FLIGHT_LAST);
    assign spd_base      = 7'(MIN_SPD) + {4'd0, bus.level, 1'b0};

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            frame_ctr_q    <= '0;
            ducks_left_q   <= '0;
            round_active_q <= 1'b0;
            round_done_q   <= 1'b0;
            direction_q    <= 1'b0;
            reflections_q  <= '0;
            v_spd_q        <= '0;
            h_spd_q        <= '0;
            start_x_q      <= '0;
            ctl_rst_q      <= 1'b0;
            shot_q         <= 1'b0;
            escaped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_ctr_q    <= frame_ctr_d;
            ducks_left_q   <= ducks_left_d;
            round_active_q <= round_active_d;
            round_done_q   <= round_done_d;
            direction_q    <= direction_d;
            reflections_q  <= reflections_d;
            v_spd_q        <= v_spd_d;
            h_spd_q        <= h_spd_d;
            start_x_q      <= start_x_d;
            ctl_rst_q      <= ctl_rst_d;
            shot_q         <= shot_d;
            escaped_q      <= escaped_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.round_start) state_d = GAP;
            GAP:     if (gap_expire) state_d = (ducks_left_q == 4'd0) ? DONE : LAUNCH;
            LAUNCH:  state_d = FLYING;
            FLYING:  if (bus.duck_hit || flight_expire) state_d = END;
            END:     state_d = GAP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic. End-of-duck and end-of-round pulses are loaded
    // on the edge that enters END/DONE, so they are high during exactly that
    // one-cycle state and drop on the way out.
    always_comb begin
        frame_ctr_d    = frame_ctr_q;
        ducks_left_d   = ducks_left_q;
        round_active_d = round_active_q;
        round_done_d   = 1'b0;
        direction_d    = direction_q;
        reflections_d  = reflections_q;
        v_spd_d        = v_spd_q;
        h_spd_d        = h_spd_q;
        start_x_d      = start_x_q;
        ctl_rst_d      = 1'b0;
        shot_d         = 1'b0;
        escaped_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.round_start) begin
                    ducks_left_d   = 4'(DUCKS_PER_ROUND);
                    round_active_d = 1'b1;
                    frame_ctr_d    = '0;
                end
            end
            GAP: begin
                if (gap_expire) begin
                    frame_ctr_d  = '0;
                    round_done_d = (ducks_left_q == 4'd0);
                end else if (bus.new_frame) begin
                    frame_ctr_d = frame_ctr_q + 10'd1;
                end
            end
            LAUNCH: begin
                direction_d   = lfsr[15];
                h_spd_d       = sat_spd(spd_base + {4'd0, lfsr[2:0]});
                v_spd_d       = sat_spd(spd_base + {4'd0, lfsr[5:3]});
                start_x_d     = 10'(START_X_MIN) + {1'b0, lfsr[14:6]};
                reflections_d = 5'd1 + {2'd0, lfsr[9:7]};
                ducks_left_d  = ducks_left_q - 4'd1;
                frame_ctr_d   = '0;
            end
            FLYING: begin
                // A hit takes priority over a timeout landing on the same edge.
                if (bus.duck_hit) begin
                    shot_d        = 1'b1;
                    ctl_rst_d     = 1'b1;
                    reflections_d = '0;
                    frame_ctr_d   = '0;
                end else if (flight_expire) begin
                    escaped_d     = 1'b1;
                    ctl_rst_d     = 1'b1;
                    reflections_d = '0;
                    frame_ctr_d   = '0;
                end else if (bus.new_frame) begin
                    frame_ctr_d = frame_ctr_q + 10'd1;
                end
            end
            END: begin
                reflections_d = '0;
                frame_ctr_d   = '0;
            end
            DONE: begin
                round_active_d = 1'b0;
            end
            default: begin
                frame_ctr_d = '0;
            end
        endcase
    end

    assign bus.duck_direction = direction_q;
    assign bus.reflections    = reflections_q;
    assign bus.duck_v_spd     = v_spd_q;
    assign bus.duck_h_spd     = h_spd_q;
    assign bus.duck_start_x   = start_x_q;
    assign bus.duck_ctl_rst   = ctl_rst_q;
    assign bus.duck_shot      = shot_q;
    assign bus.duck_escaped   = escaped_q;
    assign bus.ducks_left     = ducks_left_q;
    assign bus.round_active   = round_active_q;
    assign bus.round_done     = round_done_q;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_ctl_duck_spawner.sv
// -----------------------------------------------------------------------------
// tb_ctl_duck_spawner
//   Two spawners share the same stimulus: one with MIN_SPD=3 and one with
//   MIN_SPD=28 (speed saturation). Short frame counts keep rounds small.
//   The driver plays rounds frame by frame, works out each duck's expected
//   parameters and outcome from the game rules, and queues them; a monitor
//   pops an entry whenever a duck ends or a round completes.
// -----------------------------------------------------------------------------
module tb_ctl_duck_spawner;
    import duck_pkg::*;

    localparam int          DPR   = 3;
    localparam int          FLT   = 5;
    localparam int          GAPF  = 2;
    localparam int          MIN_A = 3;
    localparam int          MIN_B = 28;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        int dir;
        int h_a;
        int v_a;
        int h_b;
        int v_b;
        int x;
        int shot;
        int left;
    } duck_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       nf;
    logic       hit;
    logic       rs;
    logic [1:0] lvl;

    int checks   = 0;
    int failures = 0;

    duck_t exp_q[$];
    int    round_q[$];

    logic [15:0] m_lfsr;
    logic [34:0] outs_a;
    logic [34:0] outs_b;

    ctl_duck_spawner_if bus_a ();
    ctl_duck_spawner_if bus_b ();

    assign bus_a.new_frame   = nf;
    assign bus_a.round_start = rs;
    assign bus_a.level       = lvl;
    assign bus_a.duck_hit    = hit;
    assign bus_b.new_frame   = nf;
    assign bus_b.round_start = rs;
    assign bus_b.level       = lvl;
    assign bus_b.duck_hit    = hit;

    ctl_duck_spawner #(
        .DUCKS_PER_ROUND (DPR), .FLIGHT_FRAMES (FLT), .GAP_FRAMES (GAPF),
        .MIN_SPD (MIN_A), .LFSR_SEED (SEED)
    ) dut_a (.clk (clk), .rst (rst), .bus (bus_a.slave));

    ctl_duck_spawner #(
        .DUCKS_PER_ROUND (DPR), .FLIGHT_FRAMES (FLT), .GAP_FRAMES (GAPF),
        .MIN_SPD (MIN_B), .LFSR_SEED (SEED)
    ) dut_b (.clk (clk), .rst (rst), .bus (bus_b.slave));

    assign outs_a = {bus_a.duck_direction, bus_a.reflections, bus_a.duck_v_spd,
                     bus_a.duck_h_spd, bus_a.duck_start_x, bus_a.duck_ctl_rst,
                     bus_a.duck_shot, bus_a.duck_escaped, bus_a.ducks_left,
                     bus_a.round_active, bus_a.round_done};
    assign outs_b = {bus_b.duck_direction, bus_b.reflections, bus_b.duck_v_spd,
                     bus_b.duck_h_spd, bus_b.duck_start_x, bus_b.duck_ctl_rst,
                     bus_b.duck_shot, bus_b.duck_escaped, bus_b.ducks_left,
                     bus_b.round_active, bus_b.round_done};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Reference random source: x^16+x^14+x^13+x^11+1, shifting right, one
    // step per clock since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_spd(input int v);
        if (v > 31) return 31;
        if (v < 1)  return 1;
        return v;
    endfunction

    function automatic logic noise();
        return ($urandom_range(0, 7) == 0);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge: set inputs for the next rising edge, then
    // return at the following falling edge.
    task automatic tick(input logic f, input logic h, input logic r);
        nf  = f;
        hit = h;
        rs  = r;
        lvl = 2'($urandom_range(0, 3));
        @(negedge clk);
    endtask

    // GAPF frame pulses with random spacing; stray hits/starts are ignored.
    task automatic run_gap();
        for (int f = 0; f < GAPF; f++) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, noise(), noise());
            tick(1'b1, noise(), noise());
        end
    endtask

    task automatic run_duck(input int idx);
        duck_t       e;
        logic [15:0] m;
        int          mode;
        int          k;
        int          lv;
        bit          done;
        run_gap();
        m = m_lfsr;                       // LFSR value during the launch cycle
        tick(1'b0, noise(), noise());     // launch cycle; level sampled here
        lv    = int'(lvl);
        e.dir = int'(m[15]);
        e.h_a = model_spd(MIN_A + 2 * lv + int'(m[2:0]));
        e.v_a = model_spd(MIN_A + 2 * lv + int'(m[5:3]));
        e.h_b = model_spd(MIN_B + 2 * lv + int'(m[2:0]));
        e.v_b = model_spd(MIN_B + 2 * lv + int'(m[5:3]));
        e.x   = 64 + int'(m[14:6]);
        e.left = DPR - idx - 1;
        check("refl_in_flight", bus_a.reflections, 1 + int'(m[9:7]));
        check("ducks_left_in_flight", bus_a.ducks_left, e.left);
        // 0: escape, 1: hit with a frame pulse (k==FLT hits on timeout frame),
        // 2: hit on a frame-free cycle after k-1 frames.
        mode   = $urandom_range(0, 2);
        k      = $urandom_range(1, FLT);
        e.shot = (mode != 0) ? 1 : 0;
        exp_q.push_back(e);
        done = 1'b0;
        for (int f = 1; f <= FLT && !done; f++) begin
            if (mode == 2 && f == k) begin
                tick(1'b0, 1'b1, noise());
                done = 1'b1;
            end else begin
                repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, noise());
                if (mode == 1 && f == k) begin
                    tick(1'b1, 1'b1, noise());
                    done = 1'b1;
                end else begin
                    tick(1'b1, 1'b0, noise());
                end
            end
        end
        tick(1'b0, 1'b0, 1'b0);           // end-of-duck cycle
    endtask

    task automatic run_round();
        tick(1'b0, 1'b0, 1'b1);
        check("ducks_left_after_start", bus_a.ducks_left, DPR);
        check("round_active_after_start", bus_a.round_active, 1);
        for (int d = 0; d < DPR; d++) run_duck(d);
        round_q.push_back(0);
        run_gap();
        tick(1'b0, 1'b0, 1'b0);           // done cycle
        check("round_active_after_done", bus_a.round_active, 0);
        check("idle_after_done", bus_a.dbg_state, IDLE);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        duck_t e;
        if (!rst) begin
            if (bus_a.duck_ctl_rst) begin
                if (exp_q.size() == 0) begin
                    check("ctl_rst_unexpected", bus_a.duck_ctl_rst, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("duck_shot", bus_a.duck_shot, e.shot);
                    check("duck_escaped", bus_a.duck_escaped, 1 - e.shot);
                    check("direction", bus_a.duck_direction, e.dir);
                    check("h_spd", bus_a.duck_h_spd, e.h_a);
                    check("v_spd", bus_a.duck_v_spd, e.v_a);
                    check("start_x", bus_a.duck_start_x, e.x);
                    check("start_x_in_range",
                          (bus_a.duck_start_x >= 10'd64 && bus_a.duck_start_x <= 10'd575), 1);
                    check("refl_at_end", bus_a.reflections, 0);
                    check("ducks_left_at_end", bus_a.ducks_left, e.left);
                    check("ctl_rst_b", bus_b.duck_ctl_rst, 1);
                    check("h_spd_sat", bus_b.duck_h_spd, e.h_b);
                    check("v_spd_sat", bus_b.duck_v_spd, e.v_b);
                end
            end else if (bus_a.duck_shot || bus_a.duck_escaped) begin
                check("end_pulse_without_ctl_rst", {bus_a.duck_shot, bus_a.duck_escaped}, 0);
            end
            if (bus_a.round_done) begin
                if (round_q.size() == 0) begin
                    check("round_done_unexpected", bus_a.round_done, 0);
                end else begin
                    check("ducks_left_at_done", bus_a.ducks_left, round_q.pop_front());
                    check("round_active_at_done", bus_a.round_active, 1);
                    check("round_done_b", bus_b.round_done, 1);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        nf  = 1'b0;
        hit = 1'b0;
        rs  = 1'b0;
        lvl = 2'd0;
        repeat (2) @(negedge clk);
        check("outputs_in_reset_a", outs_a, 0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        check("outputs_after_reset_a", outs_a, 0);
        check("outputs_after_reset_b", outs_b, 0);
        check("state_after_reset", bus_a.dbg_state, IDLE);

        repeat (5) run_round();

        // Asynchronous reset in the middle of a flight, between clock edges.
        tick(1'b0, 1'b0, 1'b1);
        run_gap();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("state_flying_before_rst", bus_a.dbg_state, FLYING);
        #2 rst = 1'b1;
        #1;
        check("outputs_mid_flight_rst_a", outs_a, 0);
        check("outputs_mid_flight_rst_b", outs_b, 0);
        check("state_mid_flight_rst", bus_a.dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        check("idle_after_rst_release", bus_a.dbg_state, IDLE);
        check("outputs_after_rst_release", outs_a, 0);

        repeat (335) run_round();

        repeat (4) tick(1'b0, 1'b0, 1'b0);
        check("duck_queue_drained", exp_q.size(), 0);
        check("round_queue_drained", round_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
